// File: rtl/mult_pipe_hs_if.sv
`default_nettype none
// =============================================================================
// mult_pipe_hs_if : operand/result handshake bundle for mult_pipe_hs
// Revision: 1.0
// =============================================================================
interface mult_pipe_hs_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;

    // master = producer/consumer harness, slave = the multiplier
    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/mult_pipe_hs.sv
`default_nettype none
// =============================================================================
// mult_pipe_hs : pipelined signed/unsigned multiplier with valid/ready and flush
// Revision: 1.0
// =============================================================================
module mult_pipe_hs #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    mult_pipe_hs_if.slave bus
);
    localparam int c_PW = 2 * WIDTH;

    logic               w_stall;
    logic               w_in_ready;
    logic               w_accept;
    logic [c_PW-1:0]    w_a_ext;
    logic [c_PW-1:0]    w_b_ext;
    logic [c_PW-1:0]    w_prod;

    logic               r_s1_valid;
    logic               r_s1_signed;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [TAG_W-1:0]   r_s1_tag;

    logic [STAGES:2]    r_valid;
    logic [c_PW-1:0]    r_prod [2:STAGES];
    logic [TAG_W-1:0]   r_tag  [2:STAGES];

    assign w_stall    = r_valid[STAGES] && !bus.out_ready;
    assign w_in_ready = !w_stall && !flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Low 2*WIDTH bits of the extended product are exact in both modes
    assign w_a_ext = {{WIDTH{r_s1_signed & r_s1_a[WIDTH-1]}}, r_s1_a};
    assign w_b_ext = {{WIDTH{r_s1_signed & r_s1_b[WIDTH-1]}}, r_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_signed <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_tag    <= '0;
            r_valid     <= '0;
            for (int k = 2; k <= STAGES; k++) begin
                r_prod[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            // Flush kills valid bits only; stale data behind them is harmless
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_valid    <= '0;
            end else if (!w_stall) begin
                r_s1_valid <= w_accept;
                r_valid[2] <= r_s1_valid;
                for (int k = 3; k <= STAGES; k++) begin
                    r_valid[k] <= r_valid[k-1];
                end
            end

            if (!w_stall) begin
                if (w_accept) begin
                    r_s1_signed <= bus.in_signed;
                    r_s1_a      <= bus.in_a;
                    r_s1_b      <= bus.in_b;
                    r_s1_tag    <= bus.in_tag;
                end
                r_prod[2] <= w_prod;
                r_tag[2]  <= r_s1_tag;
                for (int k = 3; k <= STAGES; k++) begin
                    r_prod[k] <= r_prod[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid[STAGES];
    assign bus.out_product = r_prod[STAGES];
    assign bus.out_tag     = r_tag[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_hs.sv
`default_nettype none
// =============================================================================
// tb_mult_pipe_hs : three configurations (8/3, 4/2, 16/5) driven in lockstep
// Revision: 1.0
// =============================================================================
module tb_mult_pipe_hs;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_signed, out_ready;
    logic [15:0] a, b;
    logic [3:0]  tag;

    always #5 clk = ~clk;

    mult_pipe_hs_if #(.WIDTH(8),  .TAG_W(4)) bus0 ();
    mult_pipe_hs_if #(.WIDTH(4),  .TAG_W(4)) bus1 ();
    mult_pipe_hs_if #(.WIDTH(16), .TAG_W(4)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
    assign bus0.in_signed = in_signed; assign bus1.in_signed = in_signed; assign bus2.in_signed = in_signed;
    assign bus0.in_tag = tag;         assign bus1.in_tag = tag;         assign bus2.in_tag = tag;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;
    assign bus0.in_a = a[7:0];        assign bus1.in_a = a[3:0];        assign bus2.in_a = a;
    assign bus0.in_b = b[7:0];        assign bus1.in_b = b[3:0];        assign bus2.in_b = b;

    mult_pipe_hs #(.WIDTH(8),  .STAGES(3), .TAG_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
    mult_pipe_hs #(.WIDTH(4),  .STAGES(2), .TAG_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
    mult_pipe_hs #(.WIDTH(16), .STAGES(5), .TAG_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2));

    logic        ov [3];
    logic        ir [3];
    logic [31:0] op [3];
    logic [3:0]  ot [3];

    assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid; assign ov[2] = bus2.out_valid;
    assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;  assign ir[2] = bus2.in_ready;
    assign op[0] = {16'h0, bus0.out_product};
    assign op[1] = {24'h0, bus1.out_product};
    assign op[2] = bus2.out_product;
    assign ot[0] = bus0.out_tag;   assign ot[1] = bus1.out_tag;   assign ot[2] = bus2.out_tag;

    typedef struct {
        int          dut;
        logic [31:0] prod;
        logic [3:0]  tag;
        int          acc;
        int          snap;
    } exp_t;

    exp_t        q[$];
    int          passed = 0, total = 0, fails = 0, cyc = 0;
    int          stallc [3];
    int          fires  [3];
    bit          hold   [3];
    bit          acc    [3];
    logic [31:0] hprod  [3];
    logic [3:0]  htag   [3];

    function automatic int wid(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 4 : 16);
    endfunction

    function automatic int stg(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 2 : 5);
    endfunction

    // Integer reference: interpret operands per mode, multiply, keep 2*w bits
    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input bit s, input int w);
        longint one, m, xa, ya, p;
        one = 1;
        m   = (one << w) - 1;
        xa  = longint'(x) & m;
        ya  = longint'(y) & m;
        if (s && xa >= (one << (w - 1))) xa = xa - (one << w);
        if (s && ya >= (one << (w - 1))) ya = ya - (one << w);
        p = xa * ya;
        return 32'(p & ((one << (2 * w)) - 1));
    endfunction

    function automatic string nm_i(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            hold[i] = 1'b0;
            acc[i]  = 1'b0;
        end
    endtask

    // One clock cycle: check handshake rules, score outputs, advance to next negedge
    task automatic tick();
        #1;
        for (int i = 0; i < 3; i++) begin
            bit er, st, fi;
            int k;
            er = !(ov[i] && !out_ready) && !flush;
            st = ov[i] && !out_ready;
            fi = ov[i] && out_ready;
            check(nm_i("in_ready", i), 32'(ir[i]), 32'(er));
            if (hold[i]) begin
                check(nm_i("hold_valid", i), 32'(ov[i]), 32'd1);
                check(nm_i("hold_product", i), op[i], hprod[i]);
                check(nm_i("hold_tag", i), 32'(ot[i]), 32'(htag[i]));
            end
            hold[i]  = st && !flush;
            hprod[i] = op[i];
            htag[i]  = ot[i];
            if (st) stallc[i]++;
            if (fi) begin
                k = -1;
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].dut == i) begin
                        k = j;
                        break;
                    end
                end
                fires[i]++;
                if (k < 0) begin
                    check(nm_i("spurious_out_valid", i), 32'(ov[i]), 32'd0);
                end else begin
                    check(nm_i("product", i), op[i], q[k].prod);
                    check(nm_i("tag", i), 32'(ot[i]), 32'(q[k].tag));
                    check(nm_i("latency", i), cyc - q[k].acc, stg(i) + stallc[i] - q[k].snap);
                    q.delete(k);
                end
            end
            if (flush) begin
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].dut == i) q.delete(j);
                end
            end
            acc[i] = in_valid && er;
            if (acc[i]) begin
                q.push_back('{dut: i, prod: ref_prod(a, b, in_signed, wid(i)), tag: tag,
                              acc: cyc, snap: stallc[i]});
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input bit s, input logic [3:0] t);
        int n;
        a = x; b = y; in_signed = s; tag = t; in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc[0] && n < 40);
        check("send_accept", 32'(acc[0]), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect0(input string nm, input logic [31:0] p, input logic [3:0] t);
        int n;
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_wait"}, n, 2);
        check(nm, op[0], p);
        check({nm, "_tag"}, 32'(ot[0]), 32'(t));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, i, k, cnt;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; tag = '0;
        for (int j = 0; j < 3; j++) begin
            stallc[j] = 0;
            fires[j]  = 0;
        end
        model_reset();

        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check(nm_i("rst_out_valid", j), 32'(ov[j]), 32'd0);
            check(nm_i("rst_out_product", j), op[j], 32'd0);
            check(nm_i("rst_out_tag", j), 32'(ot[j]), 32'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 3; j++) check(nm_i("rst_in_ready", j), 32'(ir[j]), 32'd1);

        // Unsigned full-scale product, single-cycle output pulse
        send(16'h00FF, 16'h00FF, 1'b0, 4'h5);
        expect0("t1_ff_ff", 32'h0000_FE01, 4'h5);
        tick();
        check("t1_one_cycle", 32'(ov[0]), 32'd0);

        // Signed / unsigned corners
        send(16'h0080, 16'h0080, 1'b1, 4'h1); expect0("t2_min_min", 32'h4000, 4'h1);
        send(16'h00FF, 16'h0001, 1'b1, 4'h2); expect0("t2_m1_1_s",  32'hFFFF, 4'h2);
        send(16'h00FF, 16'h0001, 1'b0, 4'h3); expect0("t2_ff_1_u",  32'h00FF, 4'h3);
        send(16'h007F, 16'h0080, 1'b1, 4'h4); expect0("t2_max_min", 32'hC080, 4'h4);
        drain();

        // Streaming with a 4-cycle backpressure window
        f0 = fires[0];
        i = 0; k = 0;
        while (i < 10 && k < 60) begin
            a = 16'(i); b = 16'(i + 1); tag = 4'(i); in_signed = 1'b0; in_valid = 1'b1;
            out_ready = !(k >= 6 && k < 10);
            if (k == 7) begin
                #1;
                check("t3_stall_in_ready", 32'(ir[0]), 32'd0);
            end
            tick();
            if (acc[0]) i++;
            k++;
        end
        drain();
        check("t3_beats_out", fires[0] - f0, 10);

        // Flush with three beats in flight and a concurrent offer
        for (int j = 0; j < 3; j++) begin
            a = 16'(j + 2); b = 16'd3; tag = 4'(j + 8); in_valid = 1'b1;
            tick();
        end
        flush = 1'b1; a = 16'h0055; b = 16'h0055; tag = 4'hF; in_valid = 1'b1;
        #1;
        check("t4_flush_in_ready", 32'(ir[0]), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_valid_after_flush", 32'(ov[0]), 32'd0);
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (ov[0]) cnt++;
        end
        check("t4_no_flushed_beat", cnt, 0);
        send(16'd3, 16'd7, 1'b0, 4'h2);
        expect0("t4_after_flush", 32'd21, 4'h2);
        drain();

        // Asynchronous reset with beats in flight
        a = 16'd9; b = 16'd9; tag = 4'h1; in_valid = 1'b1; tick();
        tag = 4'h2; tick();
        in_valid = 1'b0; tick();
        check("t5_inflight_valid", 32'(ov[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(ov[0]), 32'd0);
        check("t5_rst_out_product", op[0], 32'd0);
        check("t5_rst_out_valid_w16", 32'(ov[2]), 32'd0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready_after", 32'(ir[0]), 32'd1);
        send(16'd3, 16'd5, 1'b0, 4'h6);
        expect0("t5_3x5", 32'h000F, 4'h6);
        drain();

        // Randomised sweep across all three configurations
        for (int n = 0; n < 600; n++) begin
            a = 16'($urandom); b = 16'($urandom); in_signed = 1'($urandom);
            tag = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (n < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            flush     = (n >= 300) && ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_pipe_hs.md
Name: mult_pipe_hs

Overview:
Parametrised, pipelined integer multiplier with a valid/ready handshake. It is the successor to the fixed 4-bit register-in/register-out multiplier wrappers.
- Adds configurable operand width and pipeline depth.
- Adds per-transaction signed/unsigned selection, a sideband tag, backpressure and a synchronous flush.
- Sits between an operand producer and a result consumer in datapath and multiplier-characterisation harnesses.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
STAGES, 3, total register stages from input acceptance to output (>=2); stage 1 = operand register, stages 2..STAGES = product registers.
TAG_W, 4, sideband tag width (>=1), passed through unmodified.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all in-flight transactions.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept an operand beat this cycle.
in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
in_a  input  WIDTH  multiplicand.
in_b  input  WIDTH  multiplier.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
out_product  output  2*WIDTH  product.
out_tag  output  TAG_W  tag of the result beat.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - All stage valid bits, data registers, out_product and out_tag clear to 0.
  - out_valid=0. in_ready=1 from the first cycle after deassertion.
- Stall: stall = out_valid && !out_ready.
  - All stages advance together only when !stall; the pipeline holds while stall is true.
  - Bubbles are not collapsed during a stall.
- in_ready = !stall && !flush (combinational).
- Acceptance: an operand beat is accepted on a rising edge where in_valid && in_ready. in_a, in_b, in_signed and in_tag are captured into stage 1.
  - When !stall and no beat is accepted, stage 1 valid becomes 0.
- Multiply: combinational, between stage 1 and stage 2.
  - in_signed=1: both operands sign-extended to 2*WIDTH; the result is the exact two's-complement product.
  - in_signed=0: both operands zero-extended; exact unsigned product.
  - No overflow is possible; out_product is always exact.
  - Corner case: signed min*min = 2^(2*WIDTH-2).
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles, if no stall intervenes. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when out_ready is held high.
- Output stability: while out_valid && !out_ready, out_product and out_tag hold constant.
- Beat order: beats are delivered in acceptance order. No beat is dropped or duplicated except by flush or reset.
- Tag: out_tag is the in_tag of the same beat.
- Flush (synchronous, registered):
  - On an edge with flush=1, all stage valid bits clear to 0, so out_valid=0 in the next cycle.
  - A concurrent in_valid is not accepted, because in_ready=0.
  - A concurrent out_ready handshake in that same cycle still completes; the consumer sees it.
  - Data registers need not clear.
- Reset mid-operation: all in-flight beats are discarded immediately. No partial result is emitted.
- out_valid does not depend combinationally on out_ready.

Test Plan:
1. WIDTH=8, STAGES=3, out_ready=1.
   - Unsigned 0xFF*0xFF, tag 0x5 -> out_product=0xFE01, out_tag=0x5, out_valid exactly 3 cycles after acceptance, for one cycle.
2. Signed corners:
   - 0x80*0x80 -> 0x4000.
   - 0xFF*0x01 -> 0xFFFF.
   - Same 0xFF*0x01 unsigned -> 0x00FF.
   - 0x7F*0x80 signed -> 0xC080.
3. Streaming with backpressure: 10 back-to-back beats a=i, b=i+1, tag=i.
   - Drop out_ready for 4 cycles mid-stream -> in_ready low during the stall.
   - Outputs held stable while stalled.
   - All 10 products i*(i+1) arrive in order with matching tags.
4. Flush: 3 beats in flight, assert flush with in_valid=1 for one cycle.
   - in_ready=0 that cycle; out_valid=0 next cycle.
   - No flushed or concurrently offered beat ever appears.
   - The next beat after flush completes with correct latency.
5. Reset mid-stream: deassert rst_n asynchronously between edges with 2 beats in flight.
   - out_valid and out_product go to 0 immediately.
   - After release, in_ready=1 and a new beat 3*5 -> 0x000F.
6. Parameter sweep WIDTH=4/STAGES=2 and WIDTH=16/STAGES=5.
   - Randomised signed/unsigned operands against a reference model; exact match required.
   - Latency equals STAGES.
